cpu_execute_stage: RTL

Decode/execute stage of the 16-bit CPU, directly downstream of the fetch stage (16-entry instruction memory, 4-bit program counter). It accepts one 16-bit instruction per handshake and decodes it. It executes against a 4-entry register file with zero/carry flags, and sends taken-branch redirects back to fetch. Multiply is iterative and multi-cycle, and HALT parks the stage until reset.

---
 rtl/cpu_exec_if.sv | 20 ++
 rtl/cpu_execute_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_if.sv
// cpu_exec_if: fetch <-> execute link.
// Carries the instruction handshake and the branch redirect back to fetch.
interface cpu_exec_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;

  modport master (
    output instr_valid, instr, instr_pc,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr_valid, instr, instr_pc,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cpu_execute_stage.sv
// cpu_execute_stage: decode/execute with 4-reg file, Z/C flags, iterative MUL.
// Ports: clk, reset, fe (instr in / redirect out), halted, flags, retire, dbg read.
module cpu_execute_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  cpu_exec_if.slave         fe,
  output logic              halted,
  output logic              flag_z,
  output logic              flag_c,
  output logic              retired,
  output logic [15:0]       retire_count,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_RUN, S_FLUSH, S_MUL, S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     regs_q [4];
  logic [DATA_W-1:0]     regs_d [4];
  logic                  z_q, z_d, c_q, c_d;
  logic [3:0]            rpc_q, rpc_d;
  logic                  retired_q, retired_d;
  logic [15:0]           rc_q, rc_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            mrd_q, mrd_d;

  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] a, b, imm;
  logic              accept;
  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   sum;
  logic              cout, wr, setf, taken;
  logic              unused_pc;

  assign op  = fe.instr[15:12];
  assign rd  = fe.instr[11:10];
  assign rs  = fe.instr[9:8];
  assign imm = DATA_W'(fe.instr[7:0]);
  assign a   = regs_q[rd];
  assign b   = regs_q[rs];
  assign unused_pc = ^fe.instr_pc;

  assign fe.instr_ready    = (state_q == S_RUN) && !reset;
  assign fe.redirect_valid = (state_q == S_FLUSH);
  assign fe.redirect_pc    = rpc_q;
  assign accept = fe.instr_valid && fe.instr_ready;

  assign halted       = (state_q == S_HALT);
  assign flag_z       = z_q;
  assign flag_c       = c_q;
  assign retired      = retired_q;
  assign retire_count = rc_q;
  assign dbg_data     = regs_q[dbg_sel];

  // Single-cycle datapath; sum carries borrow for SUB in its MSB.
  always_comb begin
    res   = '0;
    sum   = '0;
    cout  = 1'b0;
    wr    = 1'b0;
    setf  = 1'b0;
    taken = 1'b0;
    unique case (op)
      OP_LDI: begin res = imm; wr = 1'b1; end
      OP_MOV: begin res = b; wr = 1'b1; end
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[DATA_W-1:0]; cout = sum[DATA_W];
        wr = 1'b1; setf = 1'b1;
      end
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        res = sum[DATA_W-1:0]; cout = sum[DATA_W];
        wr = 1'b1; setf = 1'b1;
      end
      OP_AND: begin res = a & b; wr = 1'b1; setf = 1'b1; end
      OP_OR:  begin res = a | b; wr = 1'b1; setf = 1'b1; end
      OP_XOR: begin res = a ^ b; wr = 1'b1; setf = 1'b1; end
      OP_ADDI: begin
        sum = {1'b0, a} + {1'b0, imm};
        res = sum[DATA_W-1:0]; cout = sum[DATA_W];
        wr = 1'b1; setf = 1'b1;
      end
      OP_SHL: begin
        res = {a[DATA_W-2:0], 1'b0}; cout = a[DATA_W-1];
        wr = 1'b1; setf = 1'b1;
      end
      OP_SHR: begin
        res = {1'b0, a[DATA_W-1:1]}; cout = a[0];
        wr = 1'b1; setf = 1'b1;
      end
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = z_q;
      OP_JC:   taken = c_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    z_d       = z_q;
    c_d       = c_q;
    rpc_d     = rpc_q;
    retired_d = 1'b0;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    mrd_d     = mrd_q;
    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            mrd_d    = rd;
            state_d  = S_MUL;
          end else begin
            retired_d = 1'b1;
            if (op == OP_HALT) begin
              state_d = S_HALT;
            end else if (taken) begin
              rpc_d   = fe.instr[3:0];
              state_d = S_FLUSH;
            end else begin
              if (wr) regs_d[rd] = res;
              if (setf) begin
                z_d = (res == '0);
                c_d = cout;
              end
            end
          end
        end
      end
      S_FLUSH: state_d = S_RUN;
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          regs_d[mrd_q] = acc_d[DATA_W-1:0];
          z_d       = (acc_d[DATA_W-1:0] == '0);
          c_d       = |acc_d[2*DATA_W-1:DATA_W];
          retired_d = 1'b1;
          state_d   = S_RUN;
        end
      end
      default: ;
    endcase
  end

  assign rc_d = rc_q + 16'(retired_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RUN;
      regs_q    <= '{default: '0};
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      rpc_q     <= '0;
      retired_q <= 1'b0;
      rc_q      <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      mrd_q     <= '0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      z_q       <= z_d;
      c_q       <= c_d;
      rpc_q     <= rpc_d;
      retired_q <= retired_d;
      rc_q      <= rc_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      mrd_q     <= mrd_d;
    end
  end
endmodule
